// File: rtl/router_pkg.sv
// Shared router types: flit layout, port and state encodings, and XY route selection.
package router_pkg;

  localparam int COORD_W   = 4;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2
  } FLIT_TYPE_t;

  typedef struct packed {
    logic [COORD_W-1:0]             dst_x;
    logic [COORD_W-1:0]             dst_y;
    logic [PAYLOAD_W-2*COORD_W-1:0] info;
  } HEAD_VIEW_t;

  // Head and body flits share the payload bits; valid and type sit outside both views.
  typedef union packed {
    HEAD_VIEW_t           head;
    logic [PAYLOAD_W-1:0] data;
  } FLIT_PAYLOAD_t;

  typedef struct packed {
    logic          valid;
    FLIT_TYPE_t    ftype;
    FLIT_PAYLOAD_t payload;
  } FLIT_t;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    EAST  = 3'd2,
    SOUTH = 3'd3,
    WEST  = 3'd4
  } PORT_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTING = 2'd1,
    ACTIVE  = 2'd2,
    WAITING = 2'd3
  } GLOBAL_STATE_t;

  typedef enum logic {
    RX_IDLE   = 1'b0,
    RX_ACTIVE = 1'b1
  } RX_STATE_t;

  // X is resolved before Y, so a packet never turns back into the X dimension.
  function automatic PORT_t xy_route(input logic [COORD_W-1:0] dst_x,
                                     input logic [COORD_W-1:0] dst_y,
                                     input logic [COORD_W-1:0] cur_x,
                                     input logic [COORD_W-1:0] cur_y);
    PORT_t port;
    if (dst_x > cur_x)      port = EAST;
    else if (dst_x < cur_x) port = WEST;
    else if (dst_y > cur_y) port = NORTH;
    else if (dst_y < cur_y) port = SOUTH;
    else                    port = LOCAL;
    return port;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with occupancy count; pushes while full and pops while empty are ignored.
module flit_fifo
  import router_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  FLIT_t                    push_data,
  input  logic                     pop,
  output FLIT_t                    head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  FLIT_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer width equals log2(DEPTH), so wrap-around is the natural overflow.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/input_unit_fsm.sv
// Router input port: reserves buffer space per packet, routes the head flit, then streams to the crossbar.
// Optional protocol checking is enabled with INPUT_UNIT_ERR_CHECK_EN.
module input_unit_fsm
  import router_pkg::*;
#(
  parameter int                 BUF_DEPTH   = 8,
  parameter int                 MAX_PKT_LEN = 8,
  parameter logic [COORD_W-1:0] X_COORD     = '0,
  parameter logic [COORD_W-1:0] Y_COORD     = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_upstream_req,
  output logic                       o_upstream_ack,
  input  FLIT_t                      i_flit,
  output logic                       o_switch_req,
  output PORT_t                      o_out_port,
  input  logic                       i_switch_ack,
  output FLIT_t                      o_flit,
  output GLOBAL_STATE_t              o_gstate,
  output logic [$clog2(BUF_DEPTH):0] o_buf_count,
  output logic                       o_err
);

  localparam int              CNT_W   = $clog2(BUF_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] PKT_C   = CNT_W'(MAX_PKT_LEN);

  if (BUF_DEPTH < 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("input_unit_fsm: BUF_DEPTH must be a power of two and at least 2");
  end
  if (MAX_PKT_LEN < 1 || MAX_PKT_LEN > BUF_DEPTH) begin : g_bad_pkt_len
    $error("input_unit_fsm: MAX_PKT_LEN must be between 1 and BUF_DEPTH");
  end

  RX_STATE_t     rx_state, rx_next;
  GLOBAL_STATE_t gstate, gstate_next;
  PORT_t         out_port_q;

  logic             rx_write;
  logic             fifo_push;
  logic             fifo_pop;
  FLIT_t            fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  flit_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (i_flit),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rx_write       = (rx_state == RX_ACTIVE) && i_flit.valid;
  assign fifo_push      = rx_write && !fifo_full;
  assign o_upstream_ack = (rx_state == RX_IDLE) && i_upstream_req && ((DEPTH_C - fifo_count) >= PKT_C);
  assign o_out_port     = out_port_q;
  assign o_gstate       = gstate;
  assign o_buf_count    = fifo_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_state   <= RX_IDLE;
      gstate     <= IDLE;
      out_port_q <= LOCAL;
    end else begin
      rx_state <= rx_next;
      gstate   <= gstate_next;
      if (gstate == ROUTING)
        out_port_q <= xy_route(fifo_head.payload.head.dst_x, fifo_head.payload.head.dst_y, X_COORD, Y_COORD);
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (o_upstream_ack) rx_next = RX_ACTIVE;
      RX_ACTIVE: if (rx_write && i_flit.ftype == TAIL_FLIT) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  // A head entering an empty FIFO starts routing in the same cycle it is written.
  always_comb begin
    gstate_next  = gstate;
    fifo_pop     = 1'b0;
    o_flit       = '0;
    o_switch_req = 1'b0;
    case (gstate)
      IDLE: begin
        if ((!fifo_empty && fifo_head.ftype == HEAD_FLIT) ||
            (fifo_empty && fifo_push && i_flit.ftype == HEAD_FLIT))
          gstate_next = ROUTING;
      end
      ROUTING: gstate_next = WAITING;
      WAITING: begin
        o_switch_req = 1'b1;
        if (i_switch_ack) gstate_next = ACTIVE;
      end
      ACTIVE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          o_flit   = fifo_head;
          if (fifo_head.ftype == TAIL_FLIT) gstate_next = IDLE;
        end
      end
      default: gstate_next = IDLE;
    endcase
  end

`ifdef INPUT_UNIT_ERR_CHECK_EN
  logic err_q;
  logic first_pending;
  logic err_event;

  always_comb begin
    err_event = (rx_write && fifo_full) ||
                (i_flit.valid && rx_state == RX_IDLE) ||
                (rx_write && first_pending && i_flit.ftype != HEAD_FLIT) ||
                (gstate == IDLE && !fifo_empty && fifo_head.ftype != HEAD_FLIT);
  end

  // first_pending marks that the next accepted flit must open a packet.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q         <= 1'b0;
      first_pending <= 1'b0;
    end else begin
      if (err_event) err_q <= 1'b1;
      if (o_upstream_ack)  first_pending <= 1'b1;
      else if (rx_write)   first_pending <= 1'b0;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_input_unit_fsm.sv
// Directed bench for input_unit_fsm at router (1,1); forwarded flits are checked by a scoreboard monitor.
module tb_input_unit_fsm;
  import router_pkg::*;

`ifdef INPUT_UNIT_ERR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          upstream_req;
  logic          upstream_ack;
  FLIT_t         flit_in;
  logic          switch_req;
  PORT_t         out_port;
  logic          switch_ack;
  FLIT_t         flit_out;
  GLOBAL_STATE_t gstate;
  logic [3:0]    buf_count;
  logic          err;

  int         total = 0;
  int         bad   = 0;
  FLIT_t      exp_q[$];
  logic [7:0] tag   = 8'h10;

  always #5 clk = ~clk;

  input_unit_fsm #(
    .BUF_DEPTH   (8),
    .MAX_PKT_LEN (4),
    .X_COORD     (4'd1),
    .Y_COORD     (4'd1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_upstream_req (upstream_req),
    .o_upstream_ack (upstream_ack),
    .i_flit         (flit_in),
    .o_switch_req   (switch_req),
    .o_out_port     (out_port),
    .i_switch_ack   (switch_ack),
    .o_flit         (flit_out),
    .o_gstate       (gstate),
    .o_buf_count    (buf_count),
    .o_err          (err)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs change just after the rising edge; the caller checks at the following falling edge.
  task automatic apply_stimulus(input logic rst_n, input logic req, input FLIT_t f, input logic sw_ack);
    @(posedge clk);
    #1;
    reset_n      = rst_n;
    upstream_req = req;
    flit_in      = f;
    switch_ack   = sw_ack;
    @(negedge clk);
  endtask

  function automatic FLIT_t pkt_flit(input int i, input int n, input logic [3:0] dx,
                                     input logic [3:0] dy, input logic [7:0] t);
    FLIT_t f;
    f.valid        = 1'b1;
    f.ftype        = (i == 0) ? HEAD_FLIT : ((i == n - 1) ? TAIL_FLIT : BODY_FLIT);
    f.payload.data = {dx, dy, t + 8'(i)};
    return f;
  endfunction

  always @(negedge clk) begin : monitor
    FLIT_t e;
    if (flit_out.valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_flit: got 0x%0h, want no flit", flit_out);
      end else begin
        e = exp_q.pop_front();
        check_output("scoreboard_flit", 32'(flit_out), 32'(e));
      end
    end
  end

  // Packet sent with the grant always available; cycle c is relative to the request.
  task automatic send_packet(input logic [3:0] dx, input logic [3:0] dy, input int n,
                             input PORT_t exp_port, input string nm);
    FLIT_t f;
    tag = tag + 8'h10;
    for (int c = 0; c <= n + 4; c++) begin
      if (c >= 1 && c <= n) begin
        f = pkt_flit(c - 1, n, dx, dy, tag);
        exp_q.push_back(f);
      end else begin
        f = '0;
      end
      apply_stimulus(1'b1, (c == 0), f, 1'b1);
      if (c == 0) check_output({nm, "_ack"}, 32'(upstream_ack), 32'd1);
      if (c == 2) check_output({nm, "_routing"}, 32'(gstate), 32'(ROUTING));
      if (c == 3) begin
        check_output({nm, "_waiting"}, 32'(gstate), 32'(WAITING));
        check_output({nm, "_port"}, 32'(out_port), 32'(exp_port));
      end
      if (c == 4) check_output({nm, "_head_out"}, 32'(flit_out.valid), 32'd1);
      if (c == n + 4) begin
        check_output({nm, "_idle_end"}, 32'(gstate), 32'(IDLE));
        check_output({nm, "_count_end"}, 32'(buf_count), 32'd0);
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want test completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : stimulus
    FLIT_t f;
    logic  got;
    reset_n      = 1'b0;
    upstream_req = 1'b0;
    flit_in      = '0;
    switch_ack   = 1'b0;

    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    check_output("rst_gstate", 32'(gstate), 32'(IDLE));
    check_output("rst_count", 32'(buf_count), 32'd0);
    check_output("rst_switch_req", 32'(switch_req), 32'd0);
    check_output("rst_flit", 32'(flit_out), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    check_output("rst_ack", 32'(upstream_ack), 32'd0);
    check_output("rst_port", 32'(out_port), 32'(LOCAL));

    send_packet(4'd2, 4'd1, 4, EAST,  "single");
    send_packet(4'd0, 4'd1, 2, WEST,  "west");
    send_packet(4'd1, 4'd2, 2, NORTH, "north");
    send_packet(4'd1, 4'd0, 2, SOUTH, "south");
    send_packet(4'd1, 4'd1, 2, LOCAL, "local");

    $display("[TB] back-pressure");
    tag = tag + 8'h10;
    apply_stimulus(1'b1, 1'b1, '0, 1'b0);
    check_output("bp_ack1", 32'(upstream_ack), 32'd1);
    for (int i = 0; i < 4; i++) begin
      f = pkt_flit(i, 4, 4'd3, 4'd1, tag);
      exp_q.push_back(f);
      apply_stimulus(1'b1, 1'b0, f, 1'b0);
    end
    tag = tag + 8'h10;
    apply_stimulus(1'b1, 1'b1, '0, 1'b0);
    check_output("bp_ack2", 32'(upstream_ack), 32'd1);
    check_output("bp_count4", 32'(buf_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      f = pkt_flit(i, 4, 4'd0, 4'd0, tag);
      exp_q.push_back(f);
      apply_stimulus(1'b1, 1'b0, f, 1'b0);
    end
    apply_stimulus(1'b1, 1'b1, '0, 1'b0);
    check_output("bp_count8", 32'(buf_count), 32'd8);
    check_output("bp_no_ack3", 32'(upstream_ack), 32'd0);
    check_output("bp_waiting", 32'(gstate), 32'(WAITING));
    check_output("bp_switch_req", 32'(switch_req), 32'd1);
    apply_stimulus(1'b1, 1'b1, '0, 1'b1);
    check_output("bp_no_ack_grant", 32'(upstream_ack), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      apply_stimulus(1'b1, 1'b1, '0, 1'b1);
      if (upstream_ack) got = 1'b1;
    end
    check_output("bp_third_ack_seen", 32'(got), 32'd1);
    if (got) begin
      check_output("bp_third_ack_count", 32'(buf_count), 32'd4);
      tag = tag + 8'h10;
      for (int i = 0; i < 4; i++) begin
        f = pkt_flit(i, 4, 4'd1, 4'd3, tag);
        exp_q.push_back(f);
        apply_stimulus(1'b1, 1'b0, f, 1'b1);
      end
    end
    for (int k = 0; k < 40 && !(gstate == IDLE && buf_count == 4'd0); k++)
      apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    check_output("bp_drain_idle", 32'(gstate), 32'(IDLE));
    check_output("bp_drain_count", 32'(buf_count), 32'd0);

    $display("[TB] grant delay");
    tag = tag + 8'h10;
    apply_stimulus(1'b1, 1'b1, '0, 1'b0);
    check_output("gd_ack", 32'(upstream_ack), 32'd1);
    for (int i = 0; i < 2; i++) begin
      f = pkt_flit(i, 2, 4'd0, 4'd1, tag);
      exp_q.push_back(f);
      apply_stimulus(1'b1, 1'b0, f, 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(1'b1, 1'b0, '0, 1'b0);
      check_output("gd_waiting", 32'(gstate), 32'(WAITING));
      check_output("gd_switch_req", 32'(switch_req), 32'd1);
      check_output("gd_port", 32'(out_port), 32'(WEST));
      check_output("gd_flit_zero", 32'(flit_out), 32'd0);
    end
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    check_output("gd_flit_zero_grant", 32'(flit_out), 32'd0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    check_output("gd_head_out", 32'(flit_out.valid), 32'd1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b1);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    check_output("gd_idle_end", 32'(gstate), 32'(IDLE));
    check_output("gd_count_end", 32'(buf_count), 32'd0);
    check_output("err_clean", 32'(err), 32'd0);

    $display("[TB] reset mid-packet");
    tag = tag + 8'h10;
    apply_stimulus(1'b1, 1'b1, '0, 1'b0);
    check_output("rm_ack", 32'(upstream_ack), 32'd1);
    apply_stimulus(1'b1, 1'b0, pkt_flit(0, 4, 4'd2, 4'd2, tag), 1'b0);
    apply_stimulus(1'b1, 1'b0, pkt_flit(1, 4, 4'd2, 4'd2, tag), 1'b0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    check_output("rm_count", 32'(buf_count), 32'd0);
    check_output("rm_gstate", 32'(gstate), 32'(IDLE));
    check_output("rm_switch_req", 32'(switch_req), 32'd0);
    check_output("rm_flit", 32'(flit_out), 32'd0);

    $display("[TB] stray flit");
    apply_stimulus(1'b1, 1'b0, pkt_flit(1, 4, 4'd0, 4'd0, 8'hEE), 1'b0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, 1'b0, '0, 1'b0);
      check_output("err_sticky", 32'(err), 32'(EXP_ERR));
    end
    check_output("err_count", 32'(buf_count), 32'd0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0);
    check_output("err_after_reset", 32'(err), 32'd0);

    check_output("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_unit_fsm.md
Name: input_unit_fsm

Overview:
- Receiving end of the router link handshake: accepts packets from an upstream output unit and buffers them in a flit FIFO.
- Computes an XY route on the head flit, arbitrates for the crossbar with a switch req/ack handshake, then streams the buffered flits to the granted output unit until the tail.
- One instance per router input port.

Parameters:
- BUF_DEPTH, 8, FIFO depth in flits; power of two, at least 2.
- MAX_PKT_LEN, 8, maximum flits per packet including head and tail; must be at most BUF_DEPTH (elaboration assertion).
- X_COORD, 0, this router's X coordinate, COORD_W bits.
- Y_COORD, 0, this router's Y coordinate, COORD_W bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- i_upstream_req  in  1  upstream output unit requests a packet transfer
- o_upstream_ack  out  1  transfer accepted; space is reserved for a full packet
- i_flit  in  FLIT_t  incoming flit; the valid bit is common to all flit views
- o_switch_req  out  1  crossbar request toward the output unit selected by o_out_port
- o_out_port  out  PORT_t (3)  routed output port; stable while o_switch_req is high
- i_switch_ack  in  1  crossbar grant from the selected output unit
- o_flit  out  FLIT_t  flit toward the crossbar; '0 when no flit is sent
- o_gstate  out  GLOBAL_STATE_t  send-side state
- o_buf_count  out  $clog2(BUF_DEPTH)+1  current FIFO occupancy
- o_err  out  1  sticky protocol error

Behaviour:
- Reset: clk and reset_n are fixed as one clock with synchronous, active-low reset. Reset is sampled on the rising edge of clk. It clears the FIFO pointers and count, both FSMs go to IDLE, and o_err clears. All outputs read 0 or IDLE in the cycle after reset. Reset mid-packet discards all buffered flits, and no tail is emitted.
- RX FSM:
  - States are RX_IDLE and RX_ACTIVE.
  - o_upstream_ack is combinational. It equals (rx==RX_IDLE) && i_upstream_req && (BUF_DEPTH - count >= MAX_PKT_LEN), using the registered count.
  - When ack is asserted, rx goes to RX_ACTIVE on the next edge.
  - In RX_ACTIVE, every flit with valid=1 is written to the FIFO that cycle.
  - A valid flit whose type is TAIL_FLIT returns rx to RX_IDLE. The next ack is possible at the earliest one cycle later.
  - Invalid bubbles in RX_ACTIVE are ignored.
- Send FSM (o_gstate):
  - IDLE: when the FIFO is non-empty and the FIFO head is a HEAD_FLIT, go to ROUTING.
  - ROUTING (one cycle): register o_out_port using XY routing:
    - dst_x > X_COORD: EAST
    - dst_x < X_COORD: WEST
    - otherwise dst_y > Y_COORD: NORTH
    - otherwise dst_y < Y_COORD: SOUTH
    - otherwise LOCAL
    - Then go to WAITING.
  - WAITING: o_switch_req = 1. When i_switch_ack = 1, go to ACTIVE. The request is held indefinitely without ack.
  - ACTIVE:
    - If the FIFO is non-empty, pop one flit per cycle and drive it on o_flit combinationally from the FIFO head.
    - If the FIFO is empty, o_flit = '0 (bubble), and the upstream packet is still in flight.
    - Popping a TAIL_FLIT returns the FSM to IDLE on the next edge.
  - o_flit = '0 in every state other than ACTIVE.
- FIFO:
  - A simultaneous write and pop leaves count unchanged. Pointers wrap modulo BUF_DEPTH.
  - count saturates conceptually at BUF_DEPTH. A write when full is dropped, and the error is flagged only under the optional feature.
  - An ack may be issued for packet N+1 while packet N is still draining.
- The minimum head-in to head-out latency is 3 cycles: write, ROUTING, WAITING with immediate ack, then ACTIVE pops.

Optional Feature:
- Macro: INPUT_UNIT_ERR_CHECK_EN.
- When defined, o_err is set and held until reset on any of these events:
  - write while full;
  - valid flit while rx==RX_IDLE;
  - first flit after ack is not HEAD_FLIT;
  - send side in IDLE sees a non-head flit at the FIFO head.
- Offending flits are still dropped or handled as described above.
- When not defined, o_err is tied to 0 and no checking logic is generated.

Decomposition:
- router_pkg holds:
  - FLIT_t and FLIT_TYPE_t (HEAD_FLIT, BODY_FLIT, TAIL_FLIT);
  - head-view fields dst_x/dst_y and COORD_W;
  - PORT_t (LOCAL=0, NORTH=1, EAST=2, SOUTH=3, WEST=4);
  - GLOBAL_STATE_t (existing IDLE/ROUTING/ACTIVE/WAITING);
  - RX_STATE_t (new: RX_IDLE, RX_ACTIVE).
- One sub-module, flit_fifo: parameterised by depth over FLIT_t, with push, pop, head, count, full and empty.
- XY routing is a function in router_pkg.

Test Plan:
- Single packet: router (1,1), BUF_DEPTH=8, MAX_PKT_LEN=4. Drive req, then head(dst 2,1), body, body, tail on consecutive cycles.
  -> ack is high in cycle 0.
  -> ROUTING at cycle 2, o_out_port=EAST, WAITING at cycle 3.
  -> With i_switch_ack held high, o_flit shows head, body, body, tail in cycles 4 to 7.
  -> IDLE at cycle 8 and o_buf_count=0.
- Route coverage: destinations (0,1), (1,2), (1,0) and (1,1) at router (1,1).
  -> o_out_port is WEST, NORTH, SOUTH and LOCAL respectively.
- Back-pressure: BUF_DEPTH=8, MAX_PKT_LEN=4, i_switch_ack held low. Send two 4-flit packets, then req a third.
  -> Both acked; o_buf_count=8; third req gets no ack.
  -> After the grant, the third ack appears once count<=4.
- Grant delay: hold i_switch_ack low for 5 cycles.
  -> o_switch_req and o_out_port stay stable for 5 cycles.
  -> o_flit='0 until the grant.
- Reset mid-packet: assert reset_n=0 for 1 cycle after the 2nd flit.
  -> Next cycle o_buf_count=0, o_gstate=IDLE, o_switch_req=0, o_flit='0.
- With INPUT_UNIT_ERR_CHECK_EN defined: a valid body flit arrives with no prior ack.
  -> o_err=1 the next cycle and stays 1 until reset.
  -> Without the macro, o_err stays 0.
